// File: rtl/parity_chk_pkg.sv
// parity_chk_pkg
//   Shared definitions for the serial parity frame checker:
//     state_t           - checker FSM state encoding (IDLE, ACCUM, HOLD)
//     FRAME_MAX_DEFAULT - default maximum frame length in bits
//     ERR_COUNT_W       - width of the optional ERR_COUNT output
//     sat_inc()         - saturating increment for the error counter
package parity_chk_pkg;

    localparam int unsigned FRAME_MAX_DEFAULT = 255;
    localparam int unsigned ERR_COUNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/parity_frame_checker_accum.sv
// parity_accum
//   Running XOR accumulator and bit counter for one serial frame.
//   Ports:
//     clk      - clock, rising edge
//     rst      - synchronous active-high reset (acc=0, cnt=0)
//     load     - start a frame: acc <= data_bit, cnt <= 1
//     enable   - extend a frame: acc <= acc ^ data_bit, cnt <= cnt + 1
//     data_bit - serial bit being accumulated
//     acc      - XOR of all bits accumulated so far
//     cnt      - number of bits accumulated so far
module parity_accum #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic             data_bit,
    output logic             acc,
    output logic [LEN_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            acc <= data_bit;
            cnt <= LEN_W'(1);
        end else if (enable) begin
            acc <= acc ^ data_bit;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//   Checks even parity of serial frames. Each frame is a run of beats whose
//   final beat (IN_LAST) is the parity bit. A result (error flag, overflow
//   flag, bit count) is presented one cycle after the last beat and held
//   until the consumer takes it. Frames reaching FRAME_MAX bits without
//   IN_LAST are force-closed and reported as overflow + error.
//   Optional feature macro: PARITY_ERR_COUNT_EN adds ERR_COUNT, a
//   saturating count of transferred results with OUT_ERR=1.
//   Ports:
//     CLK, RST              - clock, synchronous active-high reset
//     IN_VALID/IN_READY     - serial beat handshake
//     IN_BIT, IN_LAST       - serial bit, end-of-frame marker
//     OUT_VALID/OUT_READY   - result handshake
//     OUT_ERR, OUT_OVF      - parity error, closed by length limit
//     OUT_LEN               - accepted bit count including parity bit
//     ERR_COUNT             - (PARITY_ERR_COUNT_EN only) error result count
module parity_frame_checker
    import parity_chk_pkg::*;
#(
    parameter int unsigned FRAME_MAX = FRAME_MAX_DEFAULT,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    input  logic                   IN_BIT,
    input  logic                   IN_LAST,
    output logic                   IN_READY,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_ERR,
    output logic                   OUT_OVF,
    output logic [LEN_W-1:0]       OUT_LEN
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [ERR_COUNT_W-1:0] ERR_COUNT
`endif
);

    state_t           state;
    state_t           state_next;
    logic             acc;
    logic [LEN_W-1:0] cnt;
    logic             beat_xfer;
    logic             res_xfer;
    logic             acc_load;
    logic             acc_enable;
    logic             final_acc;
    logic [LEN_W-1:0] final_cnt;
    logic             close_last;
    logic             close_ovf;

    assign beat_xfer = IN_VALID && IN_READY;
    assign res_xfer  = OUT_VALID && OUT_READY;

    assign acc_load   = beat_xfer && (state == IDLE);
    assign acc_enable = beat_xfer && (state == ACCUM);

    // Values the accumulator holds once the current beat is folded in; the
    // result is latched from these so it is ready the cycle after the beat.
    assign final_acc = (state == IDLE) ? IN_BIT : (acc ^ IN_BIT);
    assign final_cnt = (state == IDLE) ? LEN_W'(1) : (cnt + 1'b1);

    assign close_last = beat_xfer && IN_LAST;
    // A last beat landing exactly on FRAME_MAX is a normal close, not overflow.
    assign close_ovf  = beat_xfer && !IN_LAST && (final_cnt == LEN_W'(FRAME_MAX));

    parity_accum #(
        .LEN_W (LEN_W)
    ) u_accum (
        .clk      (CLK),
        .rst      (RST),
        .load     (acc_load),
        .enable   (acc_enable),
        .data_bit (IN_BIT),
        .acc      (acc),
        .cnt      (cnt)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (close_last || close_ovf) begin
                    state_next = HOLD;
                end else if (beat_xfer) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (close_last || close_ovf) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: readiness depends on state (and reset) only
    always_comb begin
        IN_READY = 1'b0;
        if (!RST && ((state == IDLE) || (state == ACCUM))) begin
            IN_READY = 1'b1;
        end
    end

    // Result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_ERR   <= 1'b0;
            OUT_OVF   <= 1'b0;
            OUT_LEN   <= '0;
        end else if (close_last || close_ovf) begin
            OUT_VALID <= 1'b1;
            OUT_ERR   <= close_ovf ? 1'b1 : final_acc;
            OUT_OVF   <= close_ovf;
            OUT_LEN   <= final_cnt;
        end else if (res_xfer) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR_COUNT <= '0;
        end else if (res_xfer && OUT_ERR) begin
            ERR_COUNT <= sat_inc(ERR_COUNT);
        end
    end
`else
    // Error counter not built.
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
module tb_parity_frame_checker;
    import parity_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_err, out_ovf;
    logic [7:0] out_len;

    logic       in_valid4 = 1'b0, in_bit4 = 1'b0, in_last4 = 1'b0, out_ready4 = 1'b0;
    logic       in_ready4, out_valid4, out_err4, out_ovf4;
    logic [2:0] out_len4;

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] err_count, err_count4;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.FRAME_MAX(255), .LEN_W(8)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_BIT(in_bit), .IN_LAST(in_last),
        .IN_READY(in_ready), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_ERR(out_err), .OUT_OVF(out_ovf), .OUT_LEN(out_len)
`ifdef PARITY_ERR_COUNT_EN
        , .ERR_COUNT(err_count)
`endif
    );

    parity_frame_checker #(.FRAME_MAX(4), .LEN_W(3)) dut4 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid4), .IN_BIT(in_bit4), .IN_LAST(in_last4),
        .IN_READY(in_ready4), .OUT_VALID(out_valid4), .OUT_READY(out_ready4),
        .OUT_ERR(out_err4), .OUT_OVF(out_ovf4), .OUT_LEN(out_len4)
`ifdef PARITY_ERR_COUNT_EN
        , .ERR_COUNT(err_count4)
`endif
    );

    task automatic beat(input logic b, input logic l);
        @(negedge clk);
        in_valid = 1'b1; in_bit = b; in_last = l;
    endtask

    task automatic beat4(input logic b, input logic l);
        @(negedge clk);
        in_valid4 = 1'b1; in_bit4 = b; in_last4 = l;
    endtask

    task automatic idle_in;
        @(negedge clk);
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        in_valid4 = 1'b0; in_bit4 = 1'b0; in_last4 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vectors++; if (out_err !== 1'b0 || out_ovf !== 1'b0) begin miscompares++; $display("FAIL rst_flags got err=%b ovf=%b exp 0 0", out_err, out_ovf); end
        vectors++; if (out_len !== 8'd0) begin miscompares++; $display("FAIL rst_out_len got %0d exp 0", out_len); end
        vectors++; if (in_ready4 !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready4 got %b exp 0", in_ready4); end
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_odd_parity;
        beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL odd_early_valid got %b exp 0", out_valid); end
        idle_in;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL odd_valid got %b exp 1", out_valid); end
        vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL odd_err got %b exp 1", out_err); end
        vectors++; if (out_len !== 8'd4) begin miscompares++; $display("FAIL odd_len got %0d exp 4", out_len); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL odd_ovf got %b exp 0", out_ovf); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL odd_hold_ready got %b exp 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL odd_valid_drop got %b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL odd_ready_back got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure;
        beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
        @(negedge clk);
        // Offer a beat during HOLD; it must not be taken.
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            vectors++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_ovf !== 1'b0 || out_len !== 8'd4) begin
                miscompares++; $display("FAIL bp_hold_%0d got v=%b e=%b o=%b len=%0d exp 1 0 0 4", i, out_valid, out_err, out_ovf, out_len);
            end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_%0d got %b exp 0", i, in_ready); end
        end
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop got %b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        beat(1'b0, 1'b1);
        idle_in;
        vectors++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_len !== 8'd1) begin
            miscompares++; $display("FAIL b2b_a got v=%b e=%b len=%0d exp 1 0 1", out_valid, out_err, out_len);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
        idle_in;
        vectors++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_len !== 8'd1 || out_ovf !== 1'b0) begin
            miscompares++; $display("FAIL b2b_b got v=%b e=%b o=%b len=%0d exp 1 1 0 1", out_valid, out_err, out_ovf, out_len);
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        beat4(1'b0, 1'b0); beat4(1'b0, 1'b0); beat4(1'b0, 1'b0); beat4(1'b0, 1'b0);
        // 5th zero bit offered immediately; held off until the result leaves.
        @(negedge clk);
        vectors++; if (out_valid4 !== 1'b1 || out_ovf4 !== 1'b1 || out_err4 !== 1'b1 || out_len4 !== 3'd4) begin
            miscompares++; $display("FAIL ovf_result got v=%b o=%b e=%b len=%0d exp 1 1 1 4", out_valid4, out_ovf4, out_err4, out_len4);
        end
        vectors++; if (in_ready4 !== 1'b0) begin miscompares++; $display("FAIL ovf_hold_ready got %b exp 0", in_ready4); end
        out_ready4 = 1'b1;
        @(negedge clk); out_ready4 = 1'b0;
        vectors++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            miscompares++; $display("FAIL ovf_release got ready=%b v=%b exp 1 0", in_ready4, out_valid4);
        end
        // 5th bit accepted at this edge; close the new frame with one more bit.
        beat4(1'b0, 1'b1);
        vectors++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL ovf_newframe_early got %b exp 0", out_valid4); end
        idle_in;
        vectors++; if (out_valid4 !== 1'b1 || out_len4 !== 3'd2 || out_err4 !== 1'b0 || out_ovf4 !== 1'b0) begin
            miscompares++; $display("FAIL ovf_newframe got v=%b len=%0d e=%b o=%b exp 1 2 0 0", out_valid4, out_len4, out_err4, out_ovf4);
        end
        out_ready4 = 1'b1;
        @(negedge clk); out_ready4 = 1'b0;
        // Last beat landing exactly on FRAME_MAX is a normal close.
        beat4(1'b1, 1'b0); beat4(1'b0, 1'b0); beat4(1'b0, 1'b0); beat4(1'b1, 1'b1);
        idle_in;
        vectors++; if (out_valid4 !== 1'b1 || out_len4 !== 3'd4 || out_err4 !== 1'b0 || out_ovf4 !== 1'b0) begin
            miscompares++; $display("FAIL max_last got v=%b len=%0d e=%b o=%b exp 1 4 0 0", out_valid4, out_len4, out_err4, out_ovf4);
        end
        out_ready4 = 1'b1;
        @(negedge clk); out_ready4 = 1'b0;
    endtask

    task automatic test_reset_mid;
        beat(1'b1, 1'b0); beat(1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
        @(negedge clk); rst = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        beat(1'b1, 1'b0); beat(1'b1, 1'b1);
        idle_in;
        vectors++; if (out_valid !== 1'b1 || out_len !== 8'd2 || out_err !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_next got v=%b len=%0d e=%b exp 1 2 0", out_valid, out_len, out_err);
        end
        // Reset while a result is pending discards it.
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        vectors++; if (out_valid !== 1'b0 || out_len !== 8'd0) begin
            miscompares++; $display("FAIL hold_rst got v=%b len=%0d exp 0 0", out_valid, out_len);
        end
    endtask

    task automatic test_err_count;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        // Each erroneous 1-bit frame takes two cycles: accept, then transfer.
        repeat (20) @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ec_mid_valid got %b exp 0", out_valid); end
`ifdef PARITY_ERR_COUNT_EN
        vectors++; if (err_count !== 8'd10) begin miscompares++; $display("FAIL ec_10 got %0d exp 10", err_count); end
`endif
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (580) @(negedge clk);
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL ec_end got v=%b ready=%b exp 0 1", out_valid, in_ready);
        end
`ifdef PARITY_ERR_COUNT_EN
        vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL ec_sat got %0d exp 255", err_count); end
`endif
    endtask

    initial begin
        test_reset;
        test_odd_parity;
        test_backpressure;
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        test_err_count;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
